// File: rtl/posit_lut_loader_if.sv
// Load and lookup bus of the runtime-programmable posit function table.
// The master side (host/DMA plus datapath) drives requests; the slave side is the table.
interface posit_lut_loader_if #(
    parameter int WIDTH = 8
);
    logic             load_start;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             load_done;
    logic             table_valid;
    logic             lookup_valid;
    logic [WIDTH-1:0] lookup_in;
    logic             lookup_out_valid;
    logic [WIDTH-1:0] lookup_out;

    modport master (
        output load_start, load_valid, load_data, lookup_valid, lookup_in,
        input  load_ready, load_done, table_valid, lookup_out_valid, lookup_out
    );

    modport slave (
        input  load_start, load_valid, load_data, lookup_valid, lookup_in,
        output load_ready, load_done, table_valid, lookup_out_valid, lookup_out
    );
endinterface

// File: rtl/posit_lut_loader.sv
// Runtime-loadable 2**WIDTH-entry lookup table for posit unary functions.
// Entries stream in over a valid/ready port in address order; lookups have 1-cycle latency.
module posit_lut_loader #(
    parameter int WIDTH = 8,
    parameter int ES    = 1
) (
    input logic                clock,
    input logic                reset,
    posit_lut_loader_if.slave  bus
);
    localparam int               DEPTH     = 1 << WIDTH;
    localparam logic [WIDTH:0]   LAST_ADDR = (WIDTH + 1)'(DEPTH - 1);
    localparam logic [WIDTH-1:0] NAR       = {1'b1, {(WIDTH - 1){1'b0}}};

    // ES only tags the table format; reject configurations that cannot be a posit.
    if (ES < 0 || ES > WIDTH - 2) begin : g_bad_es
        $error("posit_lut_loader: ES out of range for WIDTH");
    end

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
    typedef enum logic [1:0] {OUT_ZERO, OUT_NAR, OUT_RAM} out_sel_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   addr_q, addr_d;
    logic             load_done_q, load_done_d;
    logic             out_valid_q, out_valid_d;
    out_sel_t         out_sel_q, out_sel_d;
    logic             wr_en;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             table_valid;

    assign table_valid = (state_q == READY);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        load_done_d = 1'b0;
        wr_en       = 1'b0;
        // A start request always wins: any beat in the same cycle is dropped.
        if (bus.load_start) begin
            state_d = LOAD;
            addr_d  = '0;
        end else if (state_q == LOAD && bus.load_valid) begin
            wr_en  = 1'b1;
            addr_d = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
                state_d     = READY;
                load_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = bus.lookup_valid;
        out_sel_d   = out_sel_q;
        if (bus.lookup_valid) begin
            out_sel_d = table_valid ? OUT_RAM : OUT_NAR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            load_done_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sel_q   <= OUT_ZERO;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            load_done_q <= load_done_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
        end
    end

    // Plain write port and registered read port, no reset, so the array maps to block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr_q[WIDTH-1:0]] <= bus.load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (bus.lookup_valid) begin
            rd_data_q <= mem[bus.lookup_in];
        end
    end

    always_comb begin
        unique case (out_sel_q)
            OUT_RAM: bus.lookup_out = rd_data_q;
            OUT_NAR: bus.lookup_out = NAR;
            default: bus.lookup_out = '0;
        endcase
    end

    assign bus.load_ready       = (state_q == LOAD) && !bus.load_start;
    assign bus.load_done        = load_done_q;
    assign bus.table_valid      = table_valid;
    assign bus.lookup_out_valid = out_valid_q;
endmodule
